// File: rtl/corelet_sched.sv
// corelet_sched: one-tile sequencer for the corelet (weight fill/load, activation run, OFIFO drain).
// Define CORELET_SCHED_PERF_EN to add the stall_cnt_o performance counter.
module corelet_sched #(
    parameter int row    = 16,
    parameter int col    = 8,
    parameter int addr_w = 11,
    parameter int len_w  = 8,
    parameter int prop   = row + col
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [addr_w-1:0] k_base_i,
    input  logic [addr_w-1:0] a_base_i,
    input  logic [addr_w-1:0] p_base_i,
    input  logic [len_w-1:0]  n_act_i,
    input  logic              l0_full_i,
    input  logic              l0_ready_i,
    input  logic              ofifo_valid_i,
    output logic              wsram_ren_o,
    output logic              asram_ren_o,
    output logic [addr_w-1:0] sram_addr_o,
    output logic              l0_wr_o,
    output logic              l0_rd_o,
    output logic [1:0]        inst_w_o,
    output logic              ofifo_rd_o,
    output logic              psram_wen_o,
    output logic [addr_w-1:0] psram_addr_o,
    output logic              busy_o,
    output logic              done_o
`ifdef CORELET_SCHED_PERF_EN
   ,output logic [31:0]       stall_cnt_o
`endif
);
    typedef enum logic [2:0] {IDLE, K_FILL, K_LOAD, K_WAIT, A_RUN, DRAIN, DONE} state_t;

    localparam logic [len_w-1:0] col_n     = len_w'(col);
    localparam logic [len_w-1:0] wait_last = len_w'(prop - 1);

    state_t            state_q, state_d;
    logic [len_w-1:0]  cnt_q, cnt_d, pop_q, pop_d, k_q, k_d, n_q, n_d;
    logic [addr_w-1:0] kb_q, kb_d, ab_q, ab_d, pb_q, pb_d;
    logic [addr_w-1:0] sram_addr_q, sram_addr_d, psram_addr_q, psram_addr_d;
    logic              wsram_ren_q, wsram_ren_d, asram_ren_q, asram_ren_d;
    logic              l0_wr_q, l0_wr_d, l0_rd_q, l0_rd_d, ofifo_rd_q, ofifo_rd_d;
    logic              psram_wen_q, psram_wen_d, busy_q, busy_d, done_q, done_d;
    logic [1:0]        inst_w_q, inst_w_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pop_d        = pop_q;
        k_d          = k_q;
        n_d          = n_q;
        kb_d         = kb_q;
        ab_d         = ab_q;
        pb_d         = pb_q;
        wsram_ren_d  = 1'b0;
        asram_ren_d  = 1'b0;
        sram_addr_d  = sram_addr_q;
        l0_wr_d      = wsram_ren_q | asram_ren_q;
        l0_rd_d      = 1'b0;
        inst_w_d     = 2'b00;
        ofifo_rd_d   = 1'b0;
        psram_wen_d  = 1'b0;
        psram_addr_d = psram_addr_q;
        done_d       = 1'b0;
        // OFIFO drain overlaps the activation run and continues in DRAIN
        if (state_q == A_RUN || state_q == DRAIN) begin
            ofifo_rd_d = ofifo_valid_i;
            if (ofifo_rd_q) begin
                psram_wen_d  = 1'b1;
                psram_addr_d = pb_q + addr_w'(k_q);
                k_d          = k_q + 1'b1;
            end
        end
        case (state_q)
            IDLE: if (start_i) begin
                kb_d = k_base_i;
                ab_d = a_base_i;
                pb_d = p_base_i;
                n_d  = n_act_i;
                if (n_act_i == '0) begin
                    state_d = DONE;
                end else begin
                    state_d     = K_FILL;
                    wsram_ren_d = !l0_full_i;
                    sram_addr_d = l0_full_i ? sram_addr_q : k_base_i;
                    cnt_d       = l0_full_i ? '0 : len_w'(1);
                end
            end
            K_FILL: if (cnt_q != col_n) begin
                wsram_ren_d = !l0_full_i;
                sram_addr_d = l0_full_i ? sram_addr_q : kb_q + addr_w'(cnt_q);
                cnt_d       = l0_full_i ? cnt_q : cnt_q + 1'b1;
            end else if (!wsram_ren_q) begin
                state_d = K_LOAD;
                cnt_d   = '0;
            end
            K_LOAD: if (pop_q != col_n) begin
                l0_rd_d  = l0_ready_i;
                inst_w_d = l0_ready_i ? 2'b01 : 2'b00;
                pop_d    = pop_q + len_w'(l0_ready_i);
            end else begin
                state_d = K_WAIT;
                pop_d   = '0;
            end
            K_WAIT: begin
                cnt_d   = (cnt_q == wait_last) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == wait_last) ? A_RUN : K_WAIT;
            end
            A_RUN: begin
                if (cnt_q != n_q && !l0_full_i) begin
                    asram_ren_d = 1'b1;
                    sram_addr_d = ab_q + addr_w'(cnt_q);
                    cnt_d       = cnt_q + 1'b1;
                end
                if (pop_q != n_q) begin
                    l0_rd_d  = l0_ready_i;
                    inst_w_d = l0_ready_i ? 2'b10 : 2'b00;
                    pop_d    = pop_q + len_w'(l0_ready_i);
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: state_d = (k_q == n_q) ? DONE : DRAIN;
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
                pop_d   = '0;
                k_d     = '0;
            end
            default: state_d = IDLE;
        endcase
        // abort discards any read still in flight, so its L0 write is dropped too
        if (abort_i) begin
            state_d      = IDLE;
            cnt_d        = '0;
            pop_d        = '0;
            k_d          = '0;
            wsram_ren_d  = 1'b0;
            asram_ren_d  = 1'b0;
            sram_addr_d  = '0;
            l0_wr_d      = 1'b0;
            l0_rd_d      = 1'b0;
            inst_w_d     = 2'b00;
            ofifo_rd_d   = 1'b0;
            psram_wen_d  = 1'b0;
            psram_addr_d = '0;
            done_d       = 1'b0;
        end
        busy_d = (state_d != IDLE) || done_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pop_q        <= '0;
            k_q          <= '0;
            n_q          <= '0;
            kb_q         <= '0;
            ab_q         <= '0;
            pb_q         <= '0;
            wsram_ren_q  <= 1'b0;
            asram_ren_q  <= 1'b0;
            sram_addr_q  <= '0;
            l0_wr_q      <= 1'b0;
            l0_rd_q      <= 1'b0;
            inst_w_q     <= 2'b00;
            ofifo_rd_q   <= 1'b0;
            psram_wen_q  <= 1'b0;
            psram_addr_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pop_q        <= pop_d;
            k_q          <= k_d;
            n_q          <= n_d;
            kb_q         <= kb_d;
            ab_q         <= ab_d;
            pb_q         <= pb_d;
            wsram_ren_q  <= wsram_ren_d;
            asram_ren_q  <= asram_ren_d;
            sram_addr_q  <= sram_addr_d;
            l0_wr_q      <= l0_wr_d;
            l0_rd_q      <= l0_rd_d;
            inst_w_q     <= inst_w_d;
            ofifo_rd_q   <= ofifo_rd_d;
            psram_wen_q  <= psram_wen_d;
            psram_addr_q <= psram_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign wsram_ren_o  = wsram_ren_q;
    assign asram_ren_o  = asram_ren_q;
    assign sram_addr_o  = sram_addr_q;
    assign l0_wr_o      = l0_wr_q;
    assign l0_rd_o      = l0_rd_q;
    assign inst_w_o     = inst_w_q;
    assign ofifo_rd_o   = ofifo_rd_q;
    assign psram_wen_o  = psram_wen_q;
    assign psram_addr_o = psram_addr_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

`ifdef CORELET_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic        stall;

    // DRAIN only stalls while psums are still owed beyond the read already in flight
    always_comb begin
        stall   = (l0_full_i && ((state_q == K_FILL && cnt_q != col_n) || (state_q == A_RUN && cnt_q != n_q)))
               || (state_q == DRAIN && !ofifo_valid_i && (k_q + len_w'(ofifo_rd_q)) != n_q);
        stall_d = (state_q == IDLE && start_i && !abort_i) ? '0 : stall_q + 32'(stall && ~&stall_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt_o = stall_q;
`endif
endmodule
